// File: rtl/duck_flock_ctl.sv
// duck_flock_ctl
// ----------------------------------------------------------------------------
// Game controller for N_DUCKS independent ducks that share one animation and
// state timebase. It sequences rounds, counts hits, and runs a light-gun
// flash-probe sequencer. The sequencer lights one duck's target box per frame
// and attributes each trigger pull to at most one duck.
//
// Ports:
//   pclk          pixel clock, the only clock
//   rst_n         synchronous active-low reset
//   vsync         one-pclk pulse at frame start
//   a_period      vsyncs per animation tick (0 behaves as 1)
//   s_period      vsyncs per state tick (0 behaves as 1)
//   round_start   pulse: launch every duck (overrides everything else)
//   trigger       pulse: gun fired
//   sensor        gun photodiode, high = bright
//   video_active  high during active pixels
//   x_flat        duck k x position at [11k+10:11k]
//   y_flat        duck k y position at [11k+10:11k]
//   state_flat    duck k state code at [3k+2:3k]
//   invert_flat   duck k sprite mirrored (moving left)
//   frame         shared animation frame 0..3
//   flash_en      draw white target box for flash_id
//   flash_id      duck currently under probe
//   hits          hits this round, saturating at 255
//   busy          round in progress
//   round_done    one-pclk pulse when the last duck reaches DEAD
// ----------------------------------------------------------------------------
module duck_flock_ctl #(
  parameter int N_DUCKS    = 2,
  parameter int ID_W       = 3,
  parameter int SCREEN_W   = 1024,
  parameter int GROUND_Y   = 576,
  parameter int SPRITE_W   = 128,
  parameter int SPRITE_H   = 128,
  parameter int SPEED      = 4,
  parameter int FALL_SPEED = 8,
  parameter int FLY_TICKS  = 200,
  parameter int HIT_HOLD   = 8
) (
  input  logic                   pclk,
  input  logic                   rst_n,
  input  logic                   vsync,
  input  logic [7:0]             a_period,
  input  logic [7:0]             s_period,
  input  logic                   round_start,
  input  logic                   trigger,
  input  logic                   sensor,
  input  logic                   video_active,
  output logic [N_DUCKS*11-1:0]  x_flat,
  output logic [N_DUCKS*11-1:0]  y_flat,
  output logic [N_DUCKS*3-1:0]   state_flat,
  output logic [N_DUCKS-1:0]     invert_flat,
  output logic [1:0]             frame,
  output logic                   flash_en,
  output logic [ID_W-1:0]        flash_id,
  output logic [7:0]             hits,
  output logic                   busy,
  output logic                   round_done
);

  localparam logic [10:0] X_MAX = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] Y_MAX = 11'(GROUND_Y - SPRITE_H);
  localparam logic [10:0] SPD   = 11'(SPEED);
  localparam logic [10:0] FSPD  = 11'(FALL_SPEED);
  localparam int          T_W   = $clog2(FLY_TICKS + 1);
  localparam int          H_W   = $clog2(HIT_HOLD + 1);
  localparam logic [T_W-1:0] AGE_LAST  = T_W'(FLY_TICKS - 1);
  localparam logic [H_W-1:0] HOLD_LAST = H_W'(HIT_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLY    = 3'd1,
    S_HIT    = 3'd2,
    S_FALL   = 3'd3,
    S_DEAD   = 3'd4,
    S_ESCAPE = 3'd5
  } duck_state_t;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_WAIT  = 2'd1,
    P_PROBE = 2'd2
  } probe_state_t;

  // Timebase
  logic [7:0]  a_cnt_reg, s_cnt_reg;
  logic        a_tick_reg, s_tick_reg;
  logic [1:0]  frame_reg;
  logic [15:0] lfsr_reg;
  logic        lfsr_fb;
  logic [7:0]  a_last, s_last;

  // Per-duck state
  duck_state_t    state_reg [N_DUCKS];
  logic [10:0]    x_reg     [N_DUCKS];
  logic [10:0]    y_reg     [N_DUCKS];
  logic [T_W-1:0] age_reg   [N_DUCKS];
  logic [H_W-1:0] hold_reg  [N_DUCKS];
  logic [N_DUCKS-1:0] left_reg;
  logic [N_DUCKS-1:0] up_reg;

  // Probe sequencer and round bookkeeping
  probe_state_t    probe_reg;
  logic [ID_W-1:0] probe_idx_reg;
  logic            latch_reg;
  logic            flash_en_reg;
  logic [ID_W-1:0] flash_id_reg;
  logic [7:0]      hits_reg;
  logic            busy_reg;
  logic            round_done_reg;

  // Derived combinational views
  logic [9:0]         rot_bits     [N_DUCKS];
  logic [10:0]        launch_x     [N_DUCKS];
  logic [N_DUCKS-1:0] launch_right;
  logic [N_DUCKS-1:0] fly_mask, dead_mask, sel_mask, hit_mask;
  logic               probe_fly, all_dead, hit_now;
  logic               any_fly, next_ok;
  logic [ID_W-1:0]    low_fly, next_fly;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  // A period of 0 behaves like 1: tick on every vsync.
  assign a_last = (a_period == 8'd0) ? 8'd0 : a_period - 8'd1;
  assign s_last = (s_period == 8'd0) ? 8'd0 : s_period - 8'd1;

  // The probe hits only if the duck under test is still flying when the
  // frame that showed its target box ends.
  assign hit_now = (probe_reg == P_PROBE) && vsync && latch_reg && probe_fly;
  assign probe_fly = |(fly_mask & sel_mask);
  assign all_dead  = &dead_mask;

  generate
    for (genvar gi = 0; gi < N_DUCKS; gi++) begin : g_duck
      // Each duck samples the LFSR rotated right by its own index, so ducks
      // launched on the same cycle start at different x positions.
      for (genvar bi = 0; bi < 10; bi++) begin : g_rot
        assign rot_bits[gi][bi] = lfsr_reg[(bi + gi) % 16];
      end
      assign launch_x[gi]     = 11'({22'd0, rot_bits[gi]} % {21'd0, X_MAX});
      assign launch_right[gi] = lfsr_reg[gi];

      assign fly_mask[gi]  = (state_reg[gi] == S_FLY);
      assign dead_mask[gi] = (state_reg[gi] == S_DEAD);
      assign sel_mask[gi]  = (probe_idx_reg == ID_W'(gi));
      assign hit_mask[gi]  = hit_now && sel_mask[gi];

      assign x_flat[11*gi +: 11]   = x_reg[gi];
      assign y_flat[11*gi +: 11]   = y_reg[gi];
      assign state_flat[3*gi +: 3] = state_reg[gi];
    end
  endgenerate

  // Lowest flying duck overall and lowest flying duck above the probe index.
  always_comb begin
    any_fly  = 1'b0;
    low_fly  = '0;
    next_ok  = 1'b0;
    next_fly = '0;
    for (int k = N_DUCKS - 1; k >= 0; k--) begin
      if (fly_mask[k]) begin
        any_fly = 1'b1;
        low_fly = ID_W'(k);
        if (k > int'(probe_idx_reg)) begin
          next_ok  = 1'b1;
          next_fly = ID_W'(k);
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      a_cnt_reg      <= 8'd0;
      s_cnt_reg      <= 8'd0;
      a_tick_reg     <= 1'b0;
      s_tick_reg     <= 1'b0;
      frame_reg      <= 2'd0;
      lfsr_reg       <= 16'hACE1;
      probe_reg      <= P_IDLE;
      probe_idx_reg  <= '0;
      latch_reg      <= 1'b0;
      flash_en_reg   <= 1'b0;
      flash_id_reg   <= '0;
      hits_reg       <= 8'd0;
      busy_reg       <= 1'b0;
      round_done_reg <= 1'b0;
      left_reg       <= '0;
      up_reg         <= '0;
      for (int k = 0; k < N_DUCKS; k++) begin
        state_reg[k] <= S_IDLE;
        x_reg[k]     <= 11'd0;
        y_reg[k]     <= 11'd0;
        age_reg[k]   <= '0;
        hold_reg[k]  <= '0;
      end
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};

      // Dividers: the tick is registered, so it appears one pclk after the
      // vsync that completes the period.
      a_tick_reg <= 1'b0;
      s_tick_reg <= 1'b0;
      if (vsync) begin
        if (a_cnt_reg >= a_last) begin
          a_cnt_reg  <= 8'd0;
          a_tick_reg <= 1'b1;
        end else begin
          a_cnt_reg <= a_cnt_reg + 8'd1;
        end
        if (s_cnt_reg >= s_last) begin
          s_cnt_reg  <= 8'd0;
          s_tick_reg <= 1'b1;
        end else begin
          s_cnt_reg <= s_cnt_reg + 8'd1;
        end
      end

      if (a_tick_reg) frame_reg <= frame_reg + 2'd1;

      round_done_reg <= 1'b0;

      if (round_start) begin
        // Launch overrides probe, hits and any motion in this cycle.
        for (int k = 0; k < N_DUCKS; k++) begin
          state_reg[k] <= S_FLY;
          x_reg[k]     <= launch_x[k];
          y_reg[k]     <= Y_MAX;
          age_reg[k]   <= '0;
          hold_reg[k]  <= '0;
        end
        left_reg     <= ~launch_right;
        up_reg       <= '1;
        hits_reg     <= 8'd0;
        busy_reg     <= 1'b1;
        probe_reg    <= P_IDLE;
        flash_en_reg <= 1'b0;
        latch_reg    <= 1'b0;
      end else begin
        case (probe_reg)
          P_IDLE: begin
            if (trigger && any_fly) begin
              probe_reg     <= P_WAIT;
              probe_idx_reg <= low_fly;
            end
          end
          P_WAIT: begin
            if (vsync) begin
              probe_reg    <= P_PROBE;
              flash_en_reg <= 1'b1;
              flash_id_reg <= probe_idx_reg;
              latch_reg    <= 1'b0;
            end
          end
          P_PROBE: begin
            if (vsync) begin
              if (hit_now) begin
                hits_reg     <= (hits_reg == 8'hFF) ? hits_reg : hits_reg + 8'd1;
                flash_en_reg <= 1'b0;
                probe_reg    <= P_IDLE;
              end else if (next_ok) begin
                probe_idx_reg <= next_fly;
                flash_id_reg  <= next_fly;
                latch_reg     <= 1'b0;
              end else begin
                flash_en_reg <= 1'b0;
                probe_reg    <= P_IDLE;
              end
            end else if (sensor && video_active) begin
              latch_reg <= 1'b1;
            end
          end
          default: probe_reg <= P_IDLE;
        endcase

        for (int k = 0; k < N_DUCKS; k++) begin
          if (hit_mask[k]) begin
            // A hit in the same cycle as an s-tick freezes the duck.
            state_reg[k] <= S_HIT;
            hold_reg[k]  <= '0;
          end else if (s_tick_reg) begin
            case (state_reg[k])
              S_FLY: begin
                age_reg[k] <= age_reg[k] + 1'b1;
                if (age_reg[k] == AGE_LAST) state_reg[k] <= S_ESCAPE;
                if (!left_reg[k]) begin
                  if (x_reg[k] + SPD >= X_MAX) begin
                    x_reg[k]    <= X_MAX;
                    left_reg[k] <= 1'b1;
                  end else begin
                    x_reg[k] <= x_reg[k] + SPD;
                  end
                end else if (x_reg[k] <= SPD) begin
                  x_reg[k]    <= 11'd0;
                  left_reg[k] <= 1'b0;
                end else begin
                  x_reg[k] <= x_reg[k] - SPD;
                end
                if (up_reg[k]) begin
                  if (y_reg[k] <= SPD) begin
                    y_reg[k]  <= 11'd0;
                    up_reg[k] <= 1'b0;
                  end else begin
                    y_reg[k] <= y_reg[k] - SPD;
                  end
                end else if (y_reg[k] + SPD >= Y_MAX) begin
                  y_reg[k]  <= Y_MAX;
                  up_reg[k] <= 1'b1;
                end else begin
                  y_reg[k] <= y_reg[k] + SPD;
                end
              end
              S_ESCAPE: begin
                if (y_reg[k] < SPD) begin
                  y_reg[k]     <= 11'd0;
                  state_reg[k] <= S_DEAD;
                end else begin
                  y_reg[k] <= y_reg[k] - SPD;
                end
              end
              S_HIT: begin
                hold_reg[k] <= hold_reg[k] + 1'b1;
                if (hold_reg[k] == HOLD_LAST) state_reg[k] <= S_FALL;
              end
              S_FALL: begin
                if (y_reg[k] + FSPD >= Y_MAX) begin
                  y_reg[k]     <= Y_MAX;
                  state_reg[k] <= S_DEAD;
                end else begin
                  y_reg[k] <= y_reg[k] + FSPD;
                end
              end
              default: ;
            endcase
          end
        end

        if (busy_reg && all_dead) begin
          busy_reg       <= 1'b0;
          round_done_reg <= 1'b1;
        end
      end
    end
  end

  assign invert_flat = left_reg;
  assign frame       = frame_reg;
  assign flash_en    = flash_en_reg;
  assign flash_id    = flash_id_reg;
  assign hits        = hits_reg;
  assign busy        = busy_reg;
  assign round_done  = round_done_reg;

endmodule

// File: tb/tb_duck_flock_ctl.sv
// Testbench for duck_flock_ctl: randomized stimulus, a behavioural reference
// model that pushes the expected outputs for every clock into a queue, and a
// monitor that pops and compares on the opposite clock edge.
module tb_duck_flock_ctl;
  localparam int N    = 3;
  localparam int XM   = 896;
  localparam int YM   = 448;
  localparam int SP   = 4;
  localparam int FSP  = 8;
  localparam int FLYT = 200;
  localparam int HOLD = 8;
  // duck state codes
  localparam int IDLE = 0, FLY = 1, HIT = 2, FALL = 3, DEAD = 4, ESC = 5;

  logic pclk = 1'b0;
  logic rst_n, vsync, round_start, trigger, sensor, video_active;
  logic [7:0] a_period, s_period;
  logic [N*11-1:0] x_flat, y_flat;
  logic [N*3-1:0]  state_flat;
  logic [N-1:0]    invert_flat;
  logic [1:0]      frame;
  logic            flash_en;
  logic [2:0]      flash_id;
  logic [7:0]      hits;
  logic            busy, round_done;

  always #5 pclk = ~pclk;

  duck_flock_ctl #(.N_DUCKS(N), .ID_W(3)) dut (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .a_period(a_period),
    .s_period(s_period), .round_start(round_start), .trigger(trigger),
    .sensor(sensor), .video_active(video_active), .x_flat(x_flat),
    .y_flat(y_flat), .state_flat(state_flat), .invert_flat(invert_flat),
    .frame(frame), .flash_en(flash_en), .flash_id(flash_id), .hits(hits),
    .busy(busy), .round_done(round_done)
  );

  typedef struct {
    logic [N*11-1:0] x;
    logic [N*11-1:0] y;
    logic [N*3-1:0]  st;
    logic [N-1:0]    inv;
    logic [1:0]      fr;
    logic            fe;
    logic [2:0]      fid;
    logic [7:0]      hits;
    logic            busy;
    logic            done;
  } snap_t;

  snap_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  int m_lfsr, m_acnt, m_scnt, m_atick, m_stick, m_frame;
  int m_x[N], m_y[N], m_st[N], m_vx[N], m_vy[N], m_age[N], m_hold[N];
  int m_pst, m_pk, m_latch, m_flash, m_fid, m_hits, m_busy, m_done;

  function automatic int first_fly_above(input int lo, input int st[N]);
    for (int k = lo + 1; k < N; k++) if (st[k] == FLY) return k;
    return -1;
  endfunction

  task automatic model_step();
    int old_st[N];
    int old_l, old_s, hit_k, pa, ps, rot, nx, ny, j;
    bit all_dead;
    if (!rst_n) begin
      m_lfsr = 'hACE1; m_acnt = 0; m_scnt = 0; m_atick = 0; m_stick = 0; m_frame = 0;
      for (int k = 0; k < N; k++) begin
        m_x[k] = 0; m_y[k] = 0; m_st[k] = IDLE; m_vx[k] = SP; m_vy[k] = SP;
        m_age[k] = 0; m_hold[k] = 0;
      end
      m_pst = 0; m_pk = 0; m_latch = 0; m_flash = 0; m_fid = 0;
      m_hits = 0; m_busy = 0; m_done = 0;
      return;
    end
    old_st = m_st;
    old_s  = m_stick;
    old_l  = m_lfsr;
    if (m_atick) m_frame = (m_frame + 1) % 4;
    m_atick = 0; m_stick = 0;
    if (vsync) begin
      pa = (a_period == 0) ? 1 : int'(a_period);
      ps = (s_period == 0) ? 1 : int'(s_period);
      m_acnt++; if (m_acnt >= pa) begin m_acnt = 0; m_atick = 1; end
      m_scnt++; if (m_scnt >= ps) begin m_scnt = 0; m_stick = 1; end
    end
    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 'hFFFF;
    m_done = 0;
    if (round_start) begin
      for (int k = 0; k < N; k++) begin
        rot = ((old_l >> k) | (old_l << (16 - k))) & 'hFFFF;
        m_x[k] = (rot & 1023) % XM;
        m_y[k] = YM;
        m_vx[k] = ((old_l >> k) & 1) ? SP : -SP;
        m_vy[k] = -SP;
        m_st[k] = FLY; m_age[k] = 0; m_hold[k] = 0;
      end
      m_hits = 0; m_busy = 1; m_pst = 0; m_flash = 0; m_latch = 0;
      return;
    end
    hit_k = -1;
    if (m_pst == 0) begin
      j = first_fly_above(-1, old_st);
      if (trigger && j >= 0) begin m_pst = 1; m_pk = j; end
    end else if (m_pst == 1) begin
      if (vsync) begin m_pst = 2; m_flash = 1; m_fid = m_pk; m_latch = 0; end
    end else if (vsync) begin
      if (m_latch && old_st[m_pk] == FLY) begin
        hit_k = m_pk;
        if (m_hits < 255) m_hits++;
        m_flash = 0; m_pst = 0;
      end else begin
        j = first_fly_above(m_pk, old_st);
        if (j >= 0) begin m_pk = j; m_fid = j; m_latch = 0; end
        else begin m_flash = 0; m_pst = 0; end
      end
    end else if (sensor && video_active) begin
      m_latch = 1;
    end
    for (int k = 0; k < N; k++) begin
      if (k == hit_k) begin
        m_st[k] = HIT; m_hold[k] = 0;
      end else if (old_s) begin
        case (m_st[k])
          FLY: begin
            nx = m_x[k] + m_vx[k];
            if (nx >= XM) begin m_x[k] = XM; m_vx[k] = -SP; end
            else if (nx <= 0) begin m_x[k] = 0; m_vx[k] = SP; end
            else m_x[k] = nx;
            ny = m_y[k] + m_vy[k];
            if (ny >= YM) begin m_y[k] = YM; m_vy[k] = -SP; end
            else if (ny <= 0) begin m_y[k] = 0; m_vy[k] = SP; end
            else m_y[k] = ny;
            m_age[k]++;
            if (m_age[k] == FLYT) m_st[k] = ESC;
          end
          ESC: begin
            if (m_y[k] < SP) begin m_y[k] = 0; m_st[k] = DEAD; end
            else m_y[k] -= SP;
          end
          HIT: begin
            m_hold[k]++;
            if (m_hold[k] == HOLD) m_st[k] = FALL;
          end
          FALL: begin
            m_y[k] += FSP;
            if (m_y[k] >= YM) begin m_y[k] = YM; m_st[k] = DEAD; end
          end
          default: ;
        endcase
      end
    end
    all_dead = 1'b1;
    for (int k = 0; k < N; k++) if (old_st[k] != DEAD) all_dead = 1'b0;
    if (m_busy && all_dead) begin m_busy = 0; m_done = 1; end
  endtask

  function automatic snap_t make_snap();
    snap_t s;
    s.x = '0; s.y = '0; s.st = '0; s.inv = '0;
    for (int k = 0; k < N; k++) begin
      s.x[11*k +: 11] = 11'(m_x[k]);
      s.y[11*k +: 11] = 11'(m_y[k]);
      s.st[3*k +: 3]  = 3'(m_st[k]);
      s.inv[k]        = (m_vx[k] < 0);
    end
    s.fr = 2'(m_frame); s.fe = m_flash[0]; s.fid = 3'(m_fid);
    s.hits = 8'(m_hits); s.busy = m_busy[0]; s.done = m_done[0];
    return s;
  endfunction

  always @(posedge pclk) begin
    model_step();
    exp_q.push_back(make_snap());
  end

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp, input int t);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, t, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    snap_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("x_flat",      64'(x_flat),      64'(e.x),    $time);
      chk("y_flat",      64'(y_flat),      64'(e.y),    $time);
      chk("state_flat",  64'(state_flat),  64'(e.st),   $time);
      chk("invert_flat", 64'(invert_flat), 64'(e.inv),  $time);
      chk("frame",       64'(frame),       64'(e.fr),   $time);
      chk("flash_en",    64'(flash_en),    64'(e.fe),   $time);
      chk("flash_id",    64'(flash_id),    64'(e.fid),  $time);
      chk("hits",        64'(hits),        64'(e.hits), $time);
      chk("busy",        64'(busy),        64'(e.busy), $time);
      chk("round_done",  64'(round_done),  64'(e.done), $time);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit bright;
    int trig_div;
    rst_n = 1'b0; vsync = 1'b0; a_period = 8'd3; s_period = 8'd1;
    round_start = 1'b0; trigger = 1'b0; sensor = 1'b0; video_active = 1'b0;
    bright = 1'b0;
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;

    // Frame stepping with a_period=3, then a_period=0.
    for (int c = 0; c < 8 * 14; c++) begin
      @(negedge pclk);
      vsync = (c % 8 == 0);
    end
    a_period = 8'd0;
    for (int c = 0; c < 8 * 6; c++) begin
      @(negedge pclk);
      vsync = (c % 8 == 0);
    end

    // Randomized rounds, triggers, probes and mid-probe relaunches.
    for (int c = 0; c < 36000 && n_err < 50; c++) begin
      @(negedge pclk);
      if (c % 3000 == 0) begin
        a_period = 8'($urandom_range(0, 4));
        s_period = 8'($urandom_range(0, 2));
      end
      trig_div = (c < 18000) ? 200 : 2500;
      vsync = (c % 12 == 0);
      if (vsync) bright = ($urandom_range(0, 2) == 0);
      video_active = ((c % 12) >= 2) && ((c % 12) < 11);
      sensor = bright && ($urandom_range(0, 3) == 0);
      trigger = ($urandom_range(0, trig_div - 1) == 0);
      round_start = (c == 5) ||
                    ($urandom_range(0, 9999) == 0) ||
                    (m_busy == 0 && $urandom_range(0, 149) == 0) ||
                    (m_pst == 2 && $urandom_range(0, 299) == 0);
    end

    vsync = 1'b0; trigger = 1'b0; sensor = 1'b0; round_start = 1'b0; video_active = 1'b0;
    repeat (5) @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
